// File: rtl/sd_sector_rd.sv
// Wishbone master that drives the sdspi byte-exchange slave through one SD CMD17
// single-block read in SPI mode, and streams the 512 data bytes out on valid/ready.
module sd_sector_rd #(
  parameter int BLK_ADDR    = 1,
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 4096
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [31:0] lba,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  rd_dat,
  output logic        rd_vld,
  input  logic        rd_rdy,
  output logic [8:0]  m_dat_o,
  input  logic [7:0]  m_dat_i,
  output logic        m_we_o,
  output logic [1:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_CS_ON, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_CS_OFF, S_DONE
  } state_t;

  localparam logic [12:0] R1_LAST  = 13'(R1_TRIES - 1);
  localparam logic [12:0] TOK_LAST = 13'(TOKEN_TRIES - 1);

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic [8:0]  tx_q, tx_d;
  logic [31:0] arg_q, arg_d;
  logic [12:0] cnt_q, cnt_d;
  logic [8:0]  dcnt_q, dcnt_d;
  logic [7:0]  rd_dat_q, rd_dat_d;
  logic        vld_q, vld_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  cmd_byte;
  logic        need_xchg;

  always_comb begin
    cmd_byte = 8'hFF;
    case (cnt_q[2:0])
      3'd0:    cmd_byte = 8'h51;
      3'd1:    cmd_byte = arg_q[31:24];
      3'd2:    cmd_byte = arg_q[23:16];
      3'd3:    cmd_byte = arg_q[15:8];
      3'd4:    cmd_byte = arg_q[7:0];
      default: cmd_byte = 8'hFF;
    endcase
  end

  // Every state between IDLE and DONE runs exchanges, except DATA while a byte is pending.
  assign need_xchg = (state_q != S_IDLE) && (state_q != S_DONE) &&
                     !((state_q == S_DATA) && vld_q);

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    tx_d     = tx_q;
    arg_d    = arg_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    rd_dat_d = rd_dat_q;
    vld_d    = vld_q;
    code_d   = code_q;

    if (state_q == S_IDLE && start) begin
      arg_d   = (BLK_ADDR != 0) ? lba : {lba[22:0], 9'b0};
      code_d  = 2'd0;
      cnt_d   = '0;
      dcnt_d  = '0;
      state_d = S_CS_ON;
    end

    if (state_q == S_DONE) state_d = S_IDLE;

    if (!cyc_q && need_xchg) begin
      cyc_d = 1'b1;
      if (state_q == S_CS_OFF)   tx_d = 9'h1FF;
      else if (state_q == S_CMD) tx_d = {1'b0, cmd_byte};
      else                       tx_d = 9'h0FF;
    end

    if (cyc_q && m_ack_i) begin
      cyc_d = 1'b0;
      case (state_q)
        S_CS_ON: begin
          cnt_d   = '0;
          state_d = S_CMD;
        end
        S_CMD: begin
          if (cnt_q == 13'd5) begin
            cnt_d   = '0;
            state_d = S_R1;
          end else cnt_d = cnt_q + 13'd1;
        end
        S_R1: begin
          if (!m_dat_i[7]) begin
            cnt_d = '0;
            if (m_dat_i == 8'h00) state_d = S_TOKEN;
            else begin
              code_d  = 2'd1;
              state_d = S_CS_OFF;
            end
          end else if (cnt_q == R1_LAST) begin
            code_d  = 2'd3;
            state_d = S_CS_OFF;
          end else cnt_d = cnt_q + 13'd1;
        end
        S_TOKEN: begin
          if (m_dat_i == 8'hFE) begin
            dcnt_d  = '0;
            state_d = S_DATA;
          end else if (m_dat_i != 8'hFF) begin
            code_d  = 2'd2;
            state_d = S_CS_OFF;
          end else if (cnt_q == TOK_LAST) begin
            code_d  = 2'd3;
            state_d = S_CS_OFF;
          end else cnt_d = cnt_q + 13'd1;
        end
        S_DATA: begin
          rd_dat_d = m_dat_i;
          vld_d    = 1'b1;
        end
        S_CRC: begin
          if (cnt_q == 13'd1) state_d = S_CS_OFF;
          else cnt_d = cnt_q + 13'd1;
        end
        S_CS_OFF: state_d = S_DONE;
        default: ;
      endcase
    end

    if (state_q == S_DATA && vld_q && rd_rdy) begin
      vld_d = 1'b0;
      if (dcnt_q == 9'd511) begin
        cnt_d   = '0;
        state_d = S_CRC;
      end else dcnt_d = dcnt_q + 9'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      tx_q     <= 9'h1FF;
      arg_q    <= '0;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      rd_dat_q <= '0;
      vld_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      tx_q     <= tx_d;
      arg_q    <= arg_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      rd_dat_q <= rd_dat_d;
      vld_q    <= vld_d;
      code_q   <= code_d;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_DONE) && (code_q != 2'd0);
  assign err_code = code_q;
  assign rd_dat   = rd_dat_q;
  assign rd_vld   = vld_q;
  assign m_dat_o  = tx_q;
  assign m_cyc_o  = cyc_q;
  assign m_stb_o  = cyc_q;
  assign m_we_o   = cyc_q;
  assign m_sel_o  = {2{cyc_q}};

endmodule

// File: tb/tb_sd_sector_rd.sv
// Bench for sd_sector_rd: a scripted SD card answers the byte exchanges of a
// block-addressed and a byte-addressed instance; a table of reads is checked.
module tb_sd_sector_rd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b;
  logic [31:0] lba;
  logic        rd_rdy;
  logic [7:0]  m_dat_i;
  logic        ack;
  logic        sel;

  logic        busy_a, done_a, err_a, vld_a, we_a, cyc_a, stb_a, ack_a;
  logic [1:0]  code_a, msel_a;
  logic [7:0]  rdd_a;
  logic [8:0]  dato_a;
  logic        busy_b, done_b, err_b, vld_b, we_b, cyc_b, stb_b, ack_b;
  logic [1:0]  code_b, msel_b;
  logic [7:0]  rdd_b;
  logic [8:0]  dato_b;

  sd_sector_rd #(.BLK_ADDR(1)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_a), .lba(lba),
    .busy(busy_a), .done(done_a), .err(err_a), .err_code(code_a),
    .rd_dat(rdd_a), .rd_vld(vld_a), .rd_rdy(rd_rdy),
    .m_dat_o(dato_a), .m_dat_i(m_dat_i), .m_we_o(we_a), .m_sel_o(msel_a),
    .m_cyc_o(cyc_a), .m_stb_o(stb_a), .m_ack_i(ack_a));

  sd_sector_rd #(.BLK_ADDR(0)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .lba(lba),
    .busy(busy_b), .done(done_b), .err(err_b), .err_code(code_b),
    .rd_dat(rdd_b), .rd_vld(vld_b), .rd_rdy(rd_rdy),
    .m_dat_o(dato_b), .m_dat_i(m_dat_i), .m_we_o(we_b), .m_sel_o(msel_b),
    .m_cyc_o(cyc_b), .m_stb_o(stb_b), .m_ack_i(ack_b));

  assign ack_a = ack & ~sel;
  assign ack_b = ack & sel;

  logic       cyc_m, stb_m, we_m, vld_m, done_m, err_m, busy_m;
  logic [1:0] sel_m, code_m;
  logic [7:0] rd_dat_m;
  logic [8:0] dat_o_m;
  assign cyc_m    = sel ? cyc_b  : cyc_a;
  assign stb_m    = sel ? stb_b  : stb_a;
  assign we_m     = sel ? we_b   : we_a;
  assign sel_m    = sel ? msel_b : msel_a;
  assign vld_m    = sel ? vld_b  : vld_a;
  assign rd_dat_m = sel ? rdd_b  : rdd_a;
  assign dat_o_m  = sel ? dato_b : dato_a;
  assign done_m   = sel ? done_b : done_a;
  assign err_m    = sel ? err_b  : err_a;
  assign code_m   = sel ? code_b : code_a;
  assign busy_m   = sel ? busy_b : busy_a;

  typedef struct {
    logic        sel;
    logic [31:0] lba;
    int          r1_delay;
    logic [7:0]  r1_val;
    int          tok_delay;
    logic [7:0]  tok_val;
    logic        tok_never;
    int          rdy_pct;
    logic        poke;
    logic [1:0]  exp_code;
    int          exp_bytes;
    logic [31:0] exp_arg;
    int          exp_xchg;
  } vec_t;

  vec_t vecs[8];
  vec_t cfg;

  int n_chk = 0, n_fail = 0, cur_vec = 0;
  int xn = 0, lat = 0, rx_n = 0, viol = 0, data_err = 0, rdy_pct = 100;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [8:0] tx_log [0:8191];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got %0h expected %0h", cur_vec, name, got, exp);
    end
  endtask

  // Card: FF through the command frame, R1 after r1_delay FF polls, token after
  // tok_delay FFs, then data bytes 00..FF,00..FF, then filler.
  function automatic logic [7:0] resp(input int idx);
    int p, q, r;
    if (idx < 7) return 8'hFF;
    p = idx - 7;
    if (p < cfg.r1_delay) return 8'hFF;
    if (p == cfg.r1_delay) return cfg.r1_val;
    q = p - cfg.r1_delay - 1;
    if (cfg.tok_never || q < cfg.tok_delay) return 8'hFF;
    if (q == cfg.tok_delay) return cfg.tok_val;
    r = q - cfg.tok_delay - 1;
    if (r < 512) return r[7:0];
    return 8'hAA;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      ack = 1'b0;
      lat = 0;
      pv  = 1'b0;
      pr  = 1'b0;
    end else begin
      if (ack) ack = 1'b0;
      else if (cyc_m) begin
        if (lat > 0) lat--;
        else begin
          if (xn < 8192) tx_log[xn] = dat_o_m;
          m_dat_i = resp(xn);
          ack = 1'b1;
          xn++;
          lat = $urandom_range(0, 1);
        end
      end
      if (pv && !pr && (!vld_m || rd_dat_m != pd)) viol++;
      if (stb_m && vld_m) viol++;
      if (stb_m !== cyc_m || we_m !== cyc_m || sel_m !== {2{cyc_m}}) viol++;
      rd_rdy = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
      if (vld_m && rd_rdy) begin
        if (rd_dat_m != rx_n[7:0]) data_err++;
        rx_n++;
      end
      pv = vld_m;
      pr = rd_rdy;
      pd = rd_dat_m;
    end
  end

  task automatic begin_op(input vec_t v);
    cfg = v; xn = 0; rx_n = 0; viol = 0; data_err = 0;
    rdy_pct = v.rdy_pct; sel = v.sel; lat = 0;
    @(negedge clk);
    lba = v.lba;
    if (v.sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    lba = ~v.lba;
    chk("busy_after_start", 64'(busy_m), 64'(1));
  endtask

  task automatic run_vec(input vec_t v);
    logic       got, e, b;
    logic [1:0] c;
    int         bad;
    got = 1'b0; e = 1'b0; b = 1'b1; c = 2'd0;
    begin_op(v);
    for (int k = 0; k < 40000 && !got; k++) begin
      @(negedge clk);
      if (v.poke && k == 50) begin
        lba = 32'hFFFF_FFFF;
        if (v.sel) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if (done_m) begin
        got = 1'b1; e = err_m; c = code_m; b = busy_m;
      end
    end
    start_a = 1'b0; start_b = 1'b0;
    chk("done_seen", 64'(got), 64'(1));
    chk("err", 64'(e), 64'(v.exp_code != 2'd0));
    chk("err_code", 64'(c), 64'(v.exp_code));
    chk("busy_at_done", 64'(b), 64'(0));
    @(negedge clk);
    chk("done_one_cycle", 64'(done_m), 64'(0));
    chk("idle_busy", 64'(busy_m), 64'(0));
    chk("frame", 64'({tx_log[1][7:0], tx_log[2][7:0], tx_log[3][7:0],
                      tx_log[4][7:0], tx_log[5][7:0], tx_log[6][7:0]}),
                 64'({8'h51, v.exp_arg, 8'hFF}));
    chk("exchanges", 64'(xn), 64'(v.exp_xchg));
    bad = 0;
    for (int i = 0; i < xn && i < 8192; i++) begin
      if (i == xn - 1) begin
        if (tx_log[i] !== 9'h1FF) bad++;
      end else if (i == 0 || i >= 7) begin
        if (tx_log[i] !== 9'h0FF) bad++;
      end else if (tx_log[i][8] !== 1'b0) bad++;
    end
    chk("tx_bytes_cs", 64'(bad), 64'(0));
    chk("bytes_out", 64'(rx_n), 64'(v.exp_bytes));
    chk("data_order", 64'(data_err), 64'(0));
    chk("handshake_rules", 64'(viol), 64'(0));
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd5,          1,    8'h00, 3, 8'hFE, 1'b0, 100, 1'b0, 2'd0, 512, 32'd5,          528};
    vecs[1] = '{1'b1, 32'd1,          0,    8'h00, 0, 8'hFE, 1'b0, 100, 1'b0, 2'd0, 512, 32'h0000_0200, 524};
    vecs[2] = '{1'b1, 32'h0080_0000,  0,    8'h00, 0, 8'hFE, 1'b0, 30,  1'b0, 2'd0, 512, 32'h0000_0000, 524};
    vecs[3] = '{1'b0, 32'd7,          0,    8'h05, 0, 8'hFE, 1'b0, 100, 1'b0, 2'd1, 0,   32'd7,          9};
    vecs[4] = '{1'b0, 32'd9,          0,    8'h00, 2, 8'h08, 1'b0, 100, 1'b0, 2'd2, 0,   32'd9,          12};
    vecs[5] = '{1'b0, 32'd3,          0,    8'h00, 0, 8'hFE, 1'b1, 100, 1'b0, 2'd3, 0,   32'd3,          4105};
    vecs[6] = '{1'b0, 32'd4,          1000, 8'h00, 0, 8'hFE, 1'b0, 100, 1'b0, 2'd3, 0,   32'd4,          16};
    vecs[7] = '{1'b0, 32'h1234_5678,  3,    8'h00, 5, 8'hFE, 1'b0, 30,  1'b1, 2'd0, 512, 32'h1234_5678, 532};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; lba = '0; rd_rdy = 1'b1;
    m_dat_i = 8'h00; ack = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_done", 64'(done_a), 64'(0));
    chk("rst_err", 64'({err_a, code_a}), 64'(0));
    chk("rst_rd_vld", 64'({vld_a, rdd_a}), 64'(0));
    chk("rst_bus", 64'({cyc_a, stb_a, we_a, msel_a}), 64'(0));
    chk("rst_m_dat_o", 64'(dato_a), 64'(9'h1FF));
    chk("rst_m_dat_o_b", 64'(dato_b), 64'(9'h1FF));
    rst = 1'b0;

    foreach (vecs[i]) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Reset in the middle of the data phase, then a clean full read.
    cur_vec = 8;
    begin_op(vecs[0]);
    for (int k = 0; k < 20000 && rx_n < 200; k++) @(negedge clk);
    chk("reached_byte_200", 64'(rx_n >= 200), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_cyc", 64'({cyc_a, stb_a}), 64'(0));
    chk("rst_mid_vld", 64'(vld_a), 64'(0));
    chk("rst_mid_busy", 64'(busy_a), 64'(0));
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done_a) dn++;
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done_a || busy_a) dn++;
      end
      chk("rst_mid_no_done", 64'(dn), 64'(0));
    end
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
